// File: rtl/apb_pkg.sv
// Shared APB definitions used by the master and the register-file slaves.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 5;
  localparam int unsigned APB_DATA_W = 32;

  // Bit positions within pprot.
  localparam int unsigned PROT_PRIV   = 0;
  localparam int unsigned PROT_NONSEC = 1;
  localparam int unsigned PROT_INSTR  = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_master_if.sv
// Command/response handshake plus APB bus signals of the APB master.
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W = APB_ADDR_W,
  parameter int unsigned DATA_W = APB_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [2:0]        cmd_prot;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [2:0]        pprot;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_prot,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata, pprot,
    input  pready, pslverr, prdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_prot,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata, pprot,
    output pready, pslverr, prdata
  );

endinterface

// File: rtl/apb_timeout_ctr.sv
// Counts ACCESS wait cycles; expired pulses on the cycle the count would reach limit.
module apb_timeout_ctr #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Flags the wait cycle that brings the count to limit, so the FSM can react in that cycle.
  assign expired = enable && !clear && ((count_q + CNT_W'(1)) == limit);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB requester: valid/ready command in, IDLE->SETUP->ACCESS transfer out, one-cycle response.
// Optional ACCESS timeout enabled with macro APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         resetn,
  apb_master_if.master bus
);

  apb_state_e        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [2:0]        pprot_q, pprot_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              expired;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  apb_timeout_ctr #(
    .CNT_W (CntW)
  ) u_timeout_ctr (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (state_q == SETUP),
    .enable  ((state_q == ACCESS) && !bus.pready),
    .limit   (CntW'(TIMEOUT_CYCLES)),
    .expired (expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expired        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = 1'b0;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pprot_d     = pprot_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        // cmd_ready_q gates acceptance so the first cycle after reset cannot take a command.
        if (cmd_ready_q && bus.cmd_valid) begin
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          pprot_d  = bus.cmd_prot;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (bus.pready) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.pslverr;
          if (!pwrite_q) begin
            rsp_rdata_d = bus.prdata;
          end
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end else if (expired) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pprot_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pprot_q     <= pprot_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pprot     = pprot_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed, table-driven bench for apb_master with a small register-file slave model.
module tb_apb_master;
  import apb_pkg::*;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned ToCycles = 4;
`else
  localparam int unsigned ToCycles = 16;
`endif

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  prot;
    int          waits;
    logic        err;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;
  int   cur_vec;
  logic [31:0] mem [32];
  vec_t vecs [9];

  apb_master_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  apb_master #(
    .ADDR_W         (5),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (ToCycles)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %h expected %h", name, cur_vec, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    check({name, "_psel"},      32'(bus.psel), 32'd0);
    check({name, "_penable"},   32'(bus.penable), 32'd0);
    check({name, "_pwrite"},    32'(bus.pwrite), 32'd0);
    check({name, "_paddr"},     32'(bus.paddr), 32'd0);
    check({name, "_pwdata"},    bus.pwdata, 32'd0);
    check({name, "_pprot"},     32'(bus.pprot), 32'd0);
    check({name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({name, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
    check({name, "_rsp_err"},   32'(bus.rsp_err), 32'd0);
  endtask

  // Entered at #1 after an edge in a cycle where cmd_ready is expected high; returns the same way.
  task automatic run_vec(input vec_t v);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.cmd_prot  = v.prot;
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    // Keep requesting with scrambled fields while busy; the latched copies must win.
    bus.cmd_write = ~v.wr;
    bus.cmd_addr  = ~v.addr;
    bus.cmd_wdata = ~v.wdata;
    bus.cmd_prot  = ~v.prot;
    check("setup_psel", 32'(bus.psel), 32'd1);
    check("setup_penable", 32'(bus.penable), 32'd0);
    check("setup_paddr", 32'(bus.paddr), 32'(v.addr));
    check("setup_pwrite", 32'(bus.pwrite), 32'(v.wr));
    check("setup_pprot", 32'(bus.pprot), 32'(v.prot));
    check("setup_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    if (v.wr) check("setup_pwdata", bus.pwdata, v.wdata);
    for (int k = 0; k <= v.waits; k++) begin
      @(posedge clk); #1;
      check("access_sel_en", 32'({bus.psel, bus.penable}), 32'd3);
      check("access_paddr", 32'(bus.paddr), 32'(v.addr));
      check("access_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("access_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      bus.cmd_addr = bus.cmd_addr + 5'd1;
      if (k == v.waits) begin
        bus.pready  = 1'b1;
        bus.pslverr = v.err;
        bus.prdata  = v.wr ? 32'hBAD0_BAD0 : mem[v.addr];
        if (v.wr && !v.err) mem[v.addr] = v.wdata;
        bus.cmd_valid = 1'b0;
      end else begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'b1;
        bus.prdata  = 32'hFFFF_FFFF;
      end
    end
    @(posedge clk); #1;
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_err", 32'(bus.rsp_err), 32'(v.exp_err));
    check("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    check("rsp_sel_en", 32'({bus.psel, bus.penable}), 32'd0);
    check("rsp_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      check("hold_no_dup_rsp", 32'(bus.rsp_valid), 32'd0);
      check("hold_psel", 32'(bus.psel), 32'd0);
    end
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
  endtask

  initial begin
    vec_t rv;
    int bad;
    errors  = 0;
    checks  = 0;
    cur_vec = -1;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 | 32'(i);

    //          wr    addr   wdata          prot                                waits err   hold rdata          err
    vecs[0] = '{1'b1, 5'd5, 32'hDEAD_BEEF, 3'b000,                              0, 1'b0, 0, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 5'd5, 32'h0,         3'b000,                              2, 1'b0, 0, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b0, 5'd3, 32'h0,         3'(1 << PROT_NONSEC),                0, 1'b1, 2, 32'hA000_0003, 1'b1};
    vecs[3] = '{1'b1, 5'd1, 32'h0000_0011, 3'b000,                              1, 1'b0, 0, 32'hA000_0003, 1'b0};
    vecs[4] = '{1'b1, 5'd2, 32'h0000_0022, 3'b000,                              0, 1'b0, 0, 32'hA000_0003, 1'b0};
    vecs[5] = '{1'b0, 5'd1, 32'h0,         3'b000,                              0, 1'b0, 0, 32'h0000_0011, 1'b0};
    vecs[6] = '{1'b0, 5'd2, 32'h0,         3'b000,                              3, 1'b0, 0, 32'h0000_0022, 1'b0};
    vecs[7] = '{1'b1, 5'd7, 32'h0000_5555, 3'(5'b00101 & ((1 << PROT_PRIV) | (1 << PROT_INSTR))),
                                                                                0, 1'b1, 0, 32'h0000_0022, 1'b1};
    vecs[8] = '{1'b0, 5'd7, 32'h0,         3'b000,                              0, 1'b0, 0, 32'hA000_0007, 1'b0};

    resetn        = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_prot  = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    bus.prdata    = '0;
    #1;
    check_all_zero("por");
    @(posedge clk);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    check("cmd_ready_after_por", 32'(bus.cmd_ready), 32'd1);

    for (int i = 0; i < 9; i++) begin
      cur_vec = i;
      run_vec(vecs[i]);
    end

    // Reset while waiting in ACCESS.
    cur_vec = 100;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 5'd9;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_access", 32'({bus.psel, bus.penable}), 32'd3);
    #2 resetn = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    check("cmd_ready_after_rst", 32'(bus.cmd_ready), 32'd1);
    check("psel_after_rst", 32'(bus.psel), 32'd0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check("no_rsp_after_rst", 32'(bad), 32'd0);

    cur_vec = 101;
    rv = '{1'b0, 5'd5, 32'h0, 3'b000, 0, 1'b0, 0, 32'hDEAD_BEEF, 1'b0};
    run_vec(rv);

    // Slave never answers.
    cur_vec = 102;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 5'd6;
    check("to_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("to_access", 32'({bus.psel, bus.penable, bus.rsp_valid}), 32'd6);
    end
    @(posedge clk); #1;
    check("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("to_rsp_err", 32'(bus.rsp_err), 32'd1);
    check("to_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    check("to_sel_en", 32'({bus.psel, bus.penable}), 32'd0);
    @(posedge clk); #1;
    check("to_single_rsp", 32'(bus.rsp_valid), 32'd0);
`else
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b110) bad++;
    end
    check("stuck_in_access", 32'(bad), 32'd0);
    #2 resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    check("recover_cmd_ready", 32'(bus.cmd_ready), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
